// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial sequence transmitter.
// State encoding is also used by the detector benches.
package seq_tx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [3:0] PREAMBLE_DEF = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        PRE  = ST_PRE,
        DATA = ST_DATA,
        GAP  = ST_GAP
    } state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register, MSB first.
// load together with shift stores the word already advanced by one bit.
module piso_shreg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (load) begin
            sr <= shift ? (d << 1) : d;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/seq_tx_fsm.sv
// Serial sequence transmitter: optional preamble then payload, MSB first, one bit per clock.
// Build option: define SEQ_TX_PREAMBLE_EN to compile in the preamble (PRE state).
module seq_tx_fsm
    import seq_tx_pkg::*;
#(
    parameter int unsigned      DATA_W     = 8,
    parameter int unsigned      PRE_W      = 4,
    parameter logic [PRE_W-1:0] PREAMBLE   = PRE_W'(PREAMBLE_DEF),
    parameter int unsigned      GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              out,
    output logic              out_valid,
    output logic              done,
    output logic              busy
);

    localparam int unsigned CNT_MAX  = max3(PRE_W, DATA_W, GAP_CYCLES);
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             sr_shift;
    logic             sr_msb;

`ifdef SEQ_TX_PREAMBLE_EN
    logic [PRE_W-1:0] pre_sr;
`else
    logic             unused_pre;
    assign unused_pre = ^PREAMBLE;
`endif

    assign busy      = (state != IDLE);
    assign din_ready = (state == IDLE) && rst;
    assign accept    = din_valid && din_ready;

    // Advance the payload register whenever a payload bit is placed on the line.
    always_comb begin
        sr_shift = 1'b0;
        if (state == DATA) begin
            sr_shift = (cnt != '0);
        end
`ifdef SEQ_TX_PREAMBLE_EN
        if (state == PRE) begin
            sr_shift = (cnt == '0);
        end
`else
        if (accept) begin
            sr_shift = 1'b1;
        end
`endif
    end

    piso_shreg #(
        .W(DATA_W)
    ) u_sr (
        .clk  (clk),
        .load (accept),
        .shift(sr_shift),
        .d    (din),
        .msb  (sr_msb)
    );

    // cnt holds the number of cycles left in the current state after this one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_TX_PREAMBLE_EN
            pre_sr    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    if (accept) begin
                        out_valid <= 1'b1;
`ifdef SEQ_TX_PREAMBLE_EN
                        state  <= PRE;
                        cnt    <= CNT_W'(PRE_W - 1);
                        out    <= PREAMBLE[PRE_W-1];
                        pre_sr <= PREAMBLE << 1;
`else
                        state  <= DATA;
                        cnt    <= CNT_W'(DATA_W - 1);
                        out    <= din[DATA_W-1];
                        done   <= (DATA_W == 1);
`endif
                    end
                end
`ifdef SEQ_TX_PREAMBLE_EN
                PRE: begin
                    if (cnt == '0) begin
                        state <= DATA;
                        cnt   <= CNT_W'(DATA_W - 1);
                        out   <= sr_msb;
                        done  <= (DATA_W == 1);
                    end else begin
                        cnt    <= cnt - 1'b1;
                        out    <= pre_sr[PRE_W-1];
                        pre_sr <= pre_sr << 1;
                    end
                end
`endif
                DATA: begin
                    if (cnt == '0) begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                            cnt   <= CNT_W'(GAP_LOAD);
                        end
                    end else begin
                        cnt  <= cnt - 1'b1;
                        out  <= sr_msb;
                        done <= (cnt == CNT_W'(1));
                    end
                end
                GAP: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_tx_fsm.sv
// Bench for seq_tx_fsm: directed scenarios then random traffic against a frame-queue model.
// Follows SEQ_TX_PREAMBLE_EN the same way the design does.
module tb_seq_tx_fsm;

    localparam int unsigned GAP = 2;
`ifdef SEQ_TX_PREAMBLE_EN
    localparam int PRE_LEN = 4;
`else
    localparam int PRE_LEN = 0;
`endif

    typedef struct {
        logic o;
        logic v;
        logic d;
        logic b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       out;
    logic       out_valid;
    logic       done;
    logic       busy;

    int         n_chk  = 0;
    int         n_fail = 0;
    exp_t       q[$];
    exp_t       cur;
    exp_t       idle_e;
    logic [3:0] pre_pat;
    logic [15:0] cap;
    logic [15:0] last_frame;

    seq_tx_fsm #(
        .DATA_W    (8),
        .PRE_W     (4),
        .PREAMBLE  (4'b1011),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .out      (out),
        .out_valid(out_valid),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [15:0] frame_of(input logic [7:0] d);
        if (PRE_LEN > 0) return {4'b0000, pre_pat, d};
        return {8'h00, d};
    endfunction

    // Model: an accepted word expands into the full list of per-cycle line values.
    task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
        if (!r) begin
            q.delete();
            cur = idle_e;
        end else if (q.size() != 0) begin
            cur = q.pop_front();
        end else if (cur.b) begin
            cur = idle_e;
        end else if (v) begin
            for (int i = PRE_LEN - 1; i >= 0; i--) q.push_back('{pre_pat[i], 1'b1, 1'b0, 1'b1});
            for (int i = 7; i >= 0; i--) q.push_back('{d[i], 1'b1, (i == 0), 1'b1});
            for (int i = 0; i < int'(GAP); i++) q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
            cur = q.pop_front();
        end else begin
            cur = idle_e;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        rst       = r;
        din_valid = v;
        din       = d;
        @(posedge clk);
        model_edge(r, v, d);
        @(negedge clk);
        chk("out",       16'(out),       16'(cur.o));
        chk("out_valid", 16'(out_valid), 16'(cur.v));
        chk("done",      16'(done),      16'(cur.d));
        chk("busy",      16'(busy),      16'(cur.b));
        chk("din_ready", 16'(din_ready), 16'(r && !cur.b));
        if (!r) cap = '0;
        if (out_valid === 1'b1) cap = {cap[14:0], out};
        if (done === 1'b1) begin
            last_frame = cap;
            cap        = '0;
        end
    endtask

    task automatic run_idle(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, d);
    endtask

    initial begin
        idle_e     = '{1'b0, 1'b0, 1'b0, 1'b0};
        cur        = idle_e;
        pre_pat    = 4'b1011;
        cap        = '0;
        last_frame = '1;
        rst        = 1'b0;
        din_valid  = 1'b0;
        din        = '0;

        // Reset with din_valid high: nothing may be accepted.
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 8'hA5);
        step(1'b1, 1'b0, 8'h00);

        // Single frame; din changes mid-frame must not leak into the payload.
        last_frame = '1;
        step(1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, (i >= 3) ? 8'h3C : 8'hA5);
        chk("frame_a5", last_frame, frame_of(8'hA5));

        // Back-to-back with din_valid held high.
        step(1'b1, 1'b1, 8'hFF);
        last_frame = '1;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 8'h00);
        chk("frame_b2b_00", last_frame, frame_of(8'h00));
        run_idle(16, 8'h00);

        // Reset in the middle of a frame, then a fresh frame.
        step(1'b1, 1'b1, 8'hC3);
        run_idle(4, 8'hC3);
        step(1'b0, 1'b0, 8'hC3);
        step(1'b1, 1'b0, 8'h00);
        last_frame = '1;
        step(1'b1, 1'b1, 8'h5A);
        run_idle(16, 8'h00);
        chk("frame_after_rst", last_frame, frame_of(8'h5A));

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), 8'($urandom));
        end
        run_idle(16, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
